button_press_decoder: RTL

Classifies the debounced button level into single-cycle event pulses: press, release, short click, double click, long press and optional auto-repeat. Sits directly downstream of `button_debounce` and consumes its `debounce` output on the same clock. Its pulses drive control logic, such as mode selection or counters, without any further edge handling.

---
 rtl/button_press_decoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_press_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/long-press events.
// Define BUTTON_PRESS_DECODER_REPEAT_EN to build the auto-repeat pulse generator.
module button_press_decoder #(
  parameter int CLK_FREQUENCY   = 10_000_000,
  parameter int LONG_PRESS_HZ   = 1,
  parameter int DOUBLE_CLICK_HZ = 4,
  parameter int REPEAT_HZ       = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int LONG_CYCLES   = CLK_FREQUENCY / LONG_PRESS_HZ;
  localparam int DOUBLE_CYCLES = CLK_FREQUENCY / DOUBLE_CLICK_HZ;
  localparam int REPEAT_CYCLES = CLK_FREQUENCY / REPEAT_HZ;
  localparam int LD_MAX        = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
  localparam int MAX_CYCLES    = (LD_MAX > REPEAT_CYCLES) ? LD_MAX : REPEAT_CYCLES;
  localparam int CNT_W         = $clog2(MAX_CYCLES);

  // The counter holds (cycles elapsed in the state - 1), so a threshold of N
  // is hit when the pre-update value equals N-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1);
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, DOWN1, WAIT2, DOWN2, LONG} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             rise, fall;
  logic             short_d, double_d, long_d;
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
  logic             repeat_d;
`endif

  assign rise    = button & ~btn_q;
  assign fall    = ~button & btn_q;
  assign pressed = btn_q;

  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
    repeat_d = 1'b0;
`endif
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: if (rise) state_d = DOWN1;
      // A fall is checked first so a release on the threshold edge stays short.
      DOWN1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (button && cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      // A rise is checked first so a press on the window-expiry edge is a double.
      WAIT2: begin
        if (rise) begin
          state_d = DOWN2;
        end else if (cnt_q == DOUBLE_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      DOWN2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end else if (button && cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
        end
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
        else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_q         <= button;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_click   <= short_d;
      double_click  <= double_d;
      long_press    <= long_d;
    end
  end

`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) repeat_pulse <= 1'b0;
    else          repeat_pulse <= repeat_d;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
